mod_tx_scheduler: RTL and testbench
===================================

Name: mod_tx_scheduler

Overview:
- Frames the ADC byte stream and sequences it into timed symbols for the BASK and 4-ASK modulators.
- Sits between the ADC manager parallel output (byte + NEW_BYTE strobe) and the modulator symbol inputs.
- Buffers bytes in a small FIFO, prepends a preamble, and paces symbols at a fixed symbol period.
- Enables exactly one modulator per frame.

Parameters:
- SYM_CYCLES, 5000: clk cycles per symbol; legal range ≥ 2.
- FIFO_DEPTH, 4: byte FIFO depth; power of 2, ≥ 2.
- PREAMBLE, 8'hA5: sync byte sent at the start of every frame.
- GUARD_SYMS, 2: number of zero symbols sent after the last data byte.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- byte_in  in  8  ADC byte
- byte_valid  in  1  one-cycle strobe; push byte_in
- mode_sel  in  1  0 = BASK, 1 = 4-ASK; latched at frame start
- sym_out  out  2  current symbol; BASK uses {1'b0, bit}
- sym_valid  out  1  one-cycle pulse when a new symbol appears on sym_out
- mod_en_bask  out  1  BASK modulator enable
- mod_en_4ask  out  1  4-ASK modulator enable
- tx_busy  out  1  high in any state other than IDLE
- fifo_full  out  1  FIFO holds FIFO_DEPTH bytes
- overflow  out  1  sticky; a byte was dropped

Behaviour:
- Reset (rst = 0, asynchronous): FSM = IDLE, FIFO empty, all outputs 0, overflow cleared.
- Reset asserted mid-frame aborts the frame immediately; no further symbols are emitted.
- FIFO write:
  - byte_valid = 1 while not full → byte written on that edge.
  - byte_valid = 1 while full with no pop in the same cycle → byte dropped, overflow set to 1. overflow clears only on reset.
  - Simultaneous push and pop when full → both performed; count unchanged.
- FSM states: IDLE → PREAMBLE → DATA → GUARD → IDLE.
- IDLE:
  - sym_out = 0, both enables 0.
  - When the FIFO is non-empty: latch mode_sel, go to PREAMBLE.
  - Latency: a byte strobed at edge N gives the first preamble symbol with sym_valid at edge N+2.
- Enables: mod_en_bask = ~mode_l and mod_en_4ask = mode_l in every non-IDLE state.
- Changes on mode_sel mid-frame are ignored until the next IDLE → PREAMBLE transition.
- Symbol timing:
  - A down-counter loads SYM_CYCLES−1 on each new symbol.
  - The next symbol is issued on the cycle after the counter reaches 0.
  - sym_out holds stable for exactly SYM_CYCLES cycles.
  - sym_valid is high only in the first cycle of each symbol.
- Serialisation is MSB first:
  - BASK: 8 symbols per byte, sym_out = {0, b[7]} … {0, b[0]}.
  - 4-ASK: 4 symbols per byte, sym_out = b[7:6], b[5:4], b[3:2], b[1:0].
- PREAMBLE: serialise PREAMBLE, then go to DATA.
- DATA:
  - Pop the FIFO head at the start of each byte and serialise it.
  - After the last symbol of a byte: FIFO non-empty → next byte back-to-back, with no gap symbol; FIFO empty → GUARD.
- GUARD:
  - Emit GUARD_SYMS symbols of value 0, each with its own sym_valid pulse.
  - Then, if the FIFO is empty → IDLE. If the FIFO is non-empty → PREAMBLE directly, with a new frame and mode_sel re-latched.
- fifo_full is combinational from the FIFO count.
- tx_busy is registered and equals (state ≠ IDLE).

Optional Feature:
- Macro: MOD_TX_PARITY_SYM_EN.
- Defined: after each DATA byte (never after PREAMBLE), one extra symbol carrying even parity p = ^byte.
  - BASK: {0, p}.
  - 4-ASK: {0, p}.
  - Same SYM_CYCLES timing as data symbols.
- Undefined: no parity symbol; the parity logic is absent.

Test Plan:
- SYM_CYCLES = 4, mode_sel = 0, push 8'h3C once:
  - sym_valid ×18: 8 preamble symbols 1,0,1,0,0,1,0,1; then 0,0,1,1,1,1,0,0; then 0,0 guard.
  - Symbol spacing of 4 cycles; mod_en_bask = 1 throughout the frame; tx_busy falls after guard.
- mode_sel = 1, push 8'hE4:
  - Symbols 2,2,1,1 (preamble), then 3,2,1,0, then 0,0.
  - mod_en_4ask = 1 throughout the frame.
- FIFO_DEPTH = 4, push 6 bytes on consecutive cycles while the first preamble is in flight:
  - 4 bytes accepted, fifo_full = 1, overflow = 1 and remains set.
  - The frame carries exactly 4 data bytes back-to-back.
- Toggle mode_sel 0 → 1 mid-DATA: symbols remain BASK format until IDLE. The next frame uses 4-ASK.
- Push a byte during GUARD: no IDLE cycle occurs; PREAMBLE starts right after the last guard symbol.
- Assert rst low mid-DATA for 1 cycle: all outputs = 0 immediately, overflow = 0, FIFO empty. After release, no sym_valid until a new byte is pushed.
- With MOD_TX_PARITY_SYM_EN defined, BASK, byte 8'h07: a symbol {0,1} follows the 8 data symbols. With the macro undefined, no parity symbol appears.

Source files
------------

// File: rtl/mod_tx_scheduler.sv
// mod_tx_scheduler: frames the ADC byte stream into timed BASK / 4-ASK symbols.
// Bytes are buffered in a small FIFO. Each frame starts with a preamble byte,
// carries the buffered data bytes, and ends with GUARD_SYMS zero symbols.
// Each symbol is held on sym_out for SYM_CYCLES clocks.
// Optional feature: define MOD_TX_PARITY_SYM_EN to append one even-parity
// symbol after every data byte.
//
// Handshake: byte_valid is a one-cycle push strobe with no back-pressure.
// A byte offered while the FIFO is full, and not freed by a same-cycle pop,
// is dropped and sets the sticky overflow flag.
// sym_valid marks the first cycle of each symbol. The modulator samples
// sym_out on that cycle and may also rely on it staying stable until the
// next sym_valid.
module mod_tx_scheduler #(
  parameter int unsigned SYM_CYCLES = 5000,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [7:0]  PREAMBLE   = 8'hA5,
  parameter int unsigned GUARD_SYMS = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  input  logic       mode_sel,
  output logic [1:0] sym_out,
  output logic       sym_valid,
  output logic       mod_en_bask,
  output logic       mod_en_4ask,
  output logic       tx_busy,
  output logic       fifo_full,
  output logic       overflow,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PRE   = 2'd1,
    S_DATA  = 2'd2,
    S_GUARD = 2'd3
  } state_t;

  localparam int unsigned CNT_W  = $clog2(SYM_CYCLES);
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned FCNT_W = PTR_W + 1;
  localparam int unsigned IDX_W  = 8;

  localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(SYM_CYCLES - 1);
  localparam logic [FCNT_W-1:0] FULL_CNT  = FCNT_W'(FIFO_DEPTH);
  localparam logic [IDX_W-1:0]  GUARD_N   = IDX_W'(GUARD_SYMS);

  // First symbol of a byte, MSB first, in the given modulation.
  function automatic logic [1:0] first_sym(input logic [7:0] b, input logic m);
    return m ? b[7:6] : {1'b0, b[7]};
  endfunction

  // Byte with the bits of its first symbol shifted out.
  function automatic logic [7:0] shift_out(input logic [7:0] b, input logic m);
    return m ? {b[5:0], 2'b00} : {b[6:0], 1'b0};
  endfunction

  // ---------------- FIFO ----------------
  logic [7:0]        mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic              ovf_q, ovf_d;
  logic              fifo_empty, push_ok, pop;
  logic [7:0]        head;

  assign fifo_full  = (fcnt_q == FULL_CNT);
  assign fifo_empty = (fcnt_q == '0);
  assign push_ok    = byte_valid && (!fifo_full || pop);
  assign head       = mem_q[rd_ptr_q];
  assign overflow   = ovf_q;

  // Occupancy and sticky overflow; a pop frees room for a same-cycle push.
  always_comb begin
    fcnt_d = fcnt_q;
    case ({push_ok, pop})
      2'b10:   fcnt_d = fcnt_q + 1'b1;
      2'b01:   fcnt_d = fcnt_q - 1'b1;
      default: fcnt_d = fcnt_q;
    endcase
    ovf_d = ovf_q | (byte_valid & fifo_full & ~pop);
  end

  // Storage array; contents are only meaningful below the occupancy count.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= byte_in;
  end

  // FIFO pointers, count and overflow flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fcnt_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      fcnt_q <= fcnt_d;
      ovf_q  <= ovf_d;
    end
  end

  // ---------------- Symbol sequencer ----------------
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       sh_q, sh_d;
  logic             mode_q, mode_d;
  logic [1:0]       sym_q, sym_d;
  logic             sym_valid_q, issue;
  logic             busy_q, en_bask_q, en_4ask_q;
  logic [IDX_W-1:0] nsym;

`ifdef MOD_TX_PARITY_SYM_EN
  logic par_q, par_d, par_pend_q, par_pend_d;
`endif

  assign nsym = mode_q ? IDX_W'(4) : IDX_W'(8);

  // Next state. idx counts symbols already issued in the current byte or
  // guard run. A unit's completion is acted on at the next issue slot, so its
  // last symbol is held for the full period before the following symbol or
  // the return to IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    mode_d  = mode_q;
    sym_d   = sym_q;
    issue   = 1'b0;
    pop     = 1'b0;
`ifdef MOD_TX_PARITY_SYM_EN
    par_d      = par_q;
    par_pend_d = par_pend_q;
`endif
    if (state_q == S_IDLE) begin
      sym_d = '0;
      cnt_d = '0;
      idx_d = '0;
      if (!fifo_empty) begin
        state_d = S_PRE;
        mode_d  = mode_sel;
        sh_d    = PREAMBLE;
      end
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end else begin
      issue = 1'b1;
      cnt_d = CNT_LOAD;
      case (state_q)
        S_PRE: begin
          if (idx_q < nsym) begin
            sym_d = first_sym(sh_q, mode_q);
            sh_d  = shift_out(sh_q, mode_q);
            idx_d = idx_q + 1'b1;
          end else begin
            // The byte that started the frame is still buffered.
            pop     = 1'b1;
            state_d = S_DATA;
            sym_d   = first_sym(head, mode_q);
            sh_d    = shift_out(head, mode_q);
            idx_d   = IDX_W'(1);
`ifdef MOD_TX_PARITY_SYM_EN
            par_d      = ^head;
            par_pend_d = 1'b1;
`endif
          end
        end
        S_DATA: begin
          if (idx_q < nsym) begin
            sym_d = first_sym(sh_q, mode_q);
            sh_d  = shift_out(sh_q, mode_q);
            idx_d = idx_q + 1'b1;
          end
`ifdef MOD_TX_PARITY_SYM_EN
          else if (par_pend_q) begin
            sym_d      = {1'b0, par_q};
            par_pend_d = 1'b0;
          end
`endif
          else if (!fifo_empty) begin
            pop   = 1'b1;
            sym_d = first_sym(head, mode_q);
            sh_d  = shift_out(head, mode_q);
            idx_d = IDX_W'(1);
`ifdef MOD_TX_PARITY_SYM_EN
            par_d      = ^head;
            par_pend_d = 1'b1;
`endif
          end else if (GUARD_N != '0) begin
            state_d = S_GUARD;
            sym_d   = '0;
            idx_d   = IDX_W'(1);
          end else begin
            state_d = S_IDLE;
            sym_d   = '0;
            issue   = 1'b0;
            cnt_d   = '0;
            idx_d   = '0;
          end
        end
        default: begin // S_GUARD
          if (idx_q < GUARD_N) begin
            sym_d = '0;
            idx_d = idx_q + 1'b1;
          end else if (!fifo_empty) begin
            // Back-to-back frame: new preamble starts immediately, new mode.
            state_d = S_PRE;
            mode_d  = mode_sel;
            sym_d   = first_sym(PREAMBLE, mode_sel);
            sh_d    = shift_out(PREAMBLE, mode_sel);
            idx_d   = IDX_W'(1);
          end else begin
            state_d = S_IDLE;
            sym_d   = '0;
            issue   = 1'b0;
            cnt_d   = '0;
            idx_d   = '0;
          end
        end
      endcase
    end
  end

  // Sequencer state and registered outputs; enables and busy track next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      sh_q        <= '0;
      mode_q      <= 1'b0;
      sym_q       <= '0;
      sym_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      en_bask_q   <= 1'b0;
      en_4ask_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      sh_q        <= sh_d;
      mode_q      <= mode_d;
      sym_q       <= sym_d;
      sym_valid_q <= issue;
      busy_q      <= (state_d != S_IDLE);
      en_bask_q   <= (state_d != S_IDLE) & ~mode_d;
      en_4ask_q   <= (state_d != S_IDLE) &  mode_d;
    end
  end

`ifdef MOD_TX_PARITY_SYM_EN
  // Parity of the byte being serialised and whether its symbol is still owed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      par_q      <= 1'b0;
      par_pend_q <= 1'b0;
    end else begin
      par_q      <= par_d;
      par_pend_q <= par_pend_d;
    end
  end
`endif

  assign sym_out     = sym_q;
  assign sym_valid   = sym_valid_q;
  assign mod_en_bask = en_bask_q;
  assign mod_en_4ask = en_4ask_q;
  assign tx_busy     = busy_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_mod_tx_scheduler.sv
// Bench for mod_tx_scheduler with SYM_CYCLES = 4 and default FIFO/preamble/guard.
module tb_mod_tx_scheduler;

  localparam int SYM = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] byte_in = '0;
  logic       byte_valid = 1'b0;
  logic       mode_sel = 1'b0;
  logic [1:0] sym_out;
  logic       sym_valid, mod_en_bask, mod_en_4ask, tx_busy, fifo_full, overflow;
  logic [1:0] dbg_state;

  // Clock and cycle counter.
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  mod_tx_scheduler #(
    .SYM_CYCLES(SYM),
    .FIFO_DEPTH(4),
    .PREAMBLE(8'hA5),
    .GUARD_SYMS(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .byte_in(byte_in),
    .byte_valid(byte_valid),
    .mode_sel(mode_sel),
    .sym_out(sym_out),
    .sym_valid(sym_valid),
    .mod_en_bask(mod_en_bask),
    .mod_en_4ask(mod_en_4ask),
    .tx_busy(tx_busy),
    .fifo_full(fifo_full),
    .overflow(overflow),
    .dbg_state(dbg_state)
  );

  // Scoreboard state.
  logic [1:0] exp_q[$];
  logic       exp_mode = 1'b0;
  int         pass_cnt = 0;
  int         total_cnt = 0;
  int         sym_seen = 0;
  int         last_cyc = -1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    assert (got === exp) pass_cnt++;
    else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Expected symbols of one byte, MSB first.
  task automatic exp_unit(input logic [7:0] b, input logic m);
    if (m) begin
      for (int i = 0; i < 4; i++) exp_q.push_back({b[7-2*i], b[6-2*i]});
    end else begin
      for (int i = 0; i < 8; i++) exp_q.push_back({1'b0, b[7-i]});
    end
  endtask

  task automatic exp_data(input logic [7:0] b, input logic m);
    exp_unit(b, m);
`ifdef MOD_TX_PARITY_SYM_EN
    exp_q.push_back({1'b0, ^b});
`endif
  endtask

  task automatic exp_guard();
    exp_q.push_back(2'd0);
    exp_q.push_back(2'd0);
  endtask

  // Driver tasks.
  task automatic push_byte(input logic [7:0] b);
    @(negedge clk);
    byte_in    = b;
    byte_valid = 1'b1;
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic wait_syms(input int target);
    int n = 0;
    while (sym_seen < target && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("wait_syms_reached", 32'(sym_seen >= target), 1);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_drained"}, exp_q.size(), 0);
    exp_q.delete();
    n = 0;
    while (tx_busy && n < SYM + 2) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_busy_fall"}, tx_busy, 0);
  endtask

  // Monitor: compare each symbol against the queue, its enables and spacing.
  always @(negedge clk) begin
    if (!rst || !tx_busy) last_cyc = -1;
    if (rst && sym_valid) begin
      sym_seen++;
      check("sym_expected_any", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) check("sym", sym_out, exp_q.pop_front());
      check("en_bask", mod_en_bask, !exp_mode);
      check("en_4ask", mod_en_4ask, exp_mode);
      if (last_cyc >= 0) check("sym_gap", cyc - last_cyc, SYM);
      last_cyc = cyc;
    end
  end

  int base;
  int idle_cnt;

  initial begin
    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_sym_valid", sym_valid, 0);
    check("rst_sym_out", sym_out, 0);
    check("rst_en_bask", mod_en_bask, 0);
    check("rst_en_4ask", mod_en_4ask, 0);
    check("rst_busy", tx_busy, 0);
    check("rst_full", fifo_full, 0);
    check("rst_overflow", overflow, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // BASK frame, 8'h3C, with first-symbol latency.
    exp_mode = 1'b0;
    mode_sel = 1'b0;
    exp_unit(8'hA5, 1'b0);
    exp_data(8'h3C, 1'b0);
    exp_guard();
    push_byte(8'h3C);
    check("lat_n_plus_0", sym_valid, 0);
    @(negedge clk);
    check("lat_n_plus_1", sym_valid, 0);
    check("lat_busy", tx_busy, 1);
    @(negedge clk);
    check("lat_n_plus_2", sym_valid, 1);
    wait_done("bask");

    // 4-ASK frame, 8'hE4.
    exp_mode = 1'b1;
    mode_sel = 1'b1;
    exp_unit(8'hA5, 1'b1);
    exp_data(8'hE4, 1'b1);
    exp_guard();
    push_byte(8'hE4);
    wait_done("ask4");

    // Six-byte burst into a four-deep FIFO.
    exp_mode = 1'b0;
    mode_sel = 1'b0;
    exp_unit(8'hA5, 1'b0);
    for (int i = 1; i <= 4; i++) exp_data(8'(i), 1'b0);
    exp_guard();
    @(negedge clk);
    for (int i = 1; i <= 6; i++) begin
      byte_in    = 8'(i);
      byte_valid = 1'b1;
      @(negedge clk);
    end
    byte_valid = 1'b0;
    check("burst_full", fifo_full, 1);
    check("burst_overflow", overflow, 1);
    wait_done("burst");
    check("overflow_sticky", overflow, 1);
    check("burst_empty_full", fifo_full, 0);

    // mode_sel toggled mid-DATA only applies to the next frame.
    exp_mode = 1'b0;
    mode_sel = 1'b0;
    base = sym_seen;
    exp_unit(8'hA5, 1'b0);
    exp_data(8'h3C, 1'b0);
    exp_guard();
    push_byte(8'h3C);
    wait_syms(base + 10);
    mode_sel = 1'b1;
    wait_done("toggle_a");
    exp_mode = 1'b1;
    exp_unit(8'hA5, 1'b1);
    exp_data(8'h5A, 1'b1);
    exp_guard();
    push_byte(8'h5A);
    wait_done("toggle_b");

    // Byte pushed during GUARD: next preamble follows with no IDLE cycle.
    base = sym_seen;
    exp_unit(8'hA5, 1'b1);
    exp_data(8'h11, 1'b1);
    exp_guard();
    exp_unit(8'hA5, 1'b1);
    exp_data(8'h22, 1'b1);
    exp_guard();
    push_byte(8'h11);
`ifdef MOD_TX_PARITY_SYM_EN
    wait_syms(base + 10);
`else
    wait_syms(base + 9);
`endif
    push_byte(8'h22);
    idle_cnt = 0;
    for (int n = 0; n < 400 && exp_q.size() != 0; n++) begin
      if (!tx_busy) idle_cnt++;
      @(negedge clk);
    end
    check("guard_no_idle", idle_cnt, 0);
    wait_done("guard_push");

    // Asynchronous reset mid-DATA with a full FIFO.
    exp_mode = 1'b0;
    mode_sel = 1'b0;
    base = sym_seen;
    exp_unit(8'hA5, 1'b0);
    exp_data(8'h3C, 1'b0);
    exp_guard();
    push_byte(8'h3C);
    wait_syms(base + 10);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      byte_in    = 8'h50 + 8'(i);
      byte_valid = 1'b1;
      @(negedge clk);
    end
    byte_valid = 1'b0;
    check("pre_rst_full", fifo_full, 1);
    #2 rst = 1'b0;
    #1;
    check("arst_sym_valid", sym_valid, 0);
    check("arst_sym_out", sym_out, 0);
    check("arst_en_bask", mod_en_bask, 0);
    check("arst_en_4ask", mod_en_4ask, 0);
    check("arst_busy", tx_busy, 0);
    check("arst_full", fifo_full, 0);
    check("arst_overflow", overflow, 0);
    exp_q.delete();
    @(negedge clk);
    #2 rst = 1'b1;
    base = sym_seen;
    repeat (60) @(negedge clk);
    check("post_rst_silent", sym_seen - base, 0);
    check("post_rst_idle", tx_busy, 0);

    // Recovery frame, then a byte with odd parity (8'h07).
    exp_unit(8'hA5, 1'b0);
    exp_data(8'h81, 1'b0);
    exp_guard();
    push_byte(8'h81);
    wait_done("recover");
    exp_unit(8'hA5, 1'b0);
    exp_data(8'h07, 1'b0);
    exp_guard();
    push_byte(8'h07);
    wait_done("parity");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
